// File: rtl/watch_rtc_core.sv
// watch_rtc_core
//   Time-of-day counter for the watch. Counts 1 ms ticks from the upstream
//   interval timer. Hours, minutes and seconds are kept in BCD and
//   milliseconds in binary. The time is compared against a programmable
//   alarm, and seconds and alarm events are raised. The block is exposed
//   as a 16-bit Avalon-MM slave with a registered, wait-free read.
//
// Parameters
//   TICK_DIV   tick_in rising edges per millisecond (1..255)
//   MS_WRAP    milliseconds per second; ms counts 0..MS_WRAP-1
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tick_in     ms tick (pulse or level; only the rising edge counts)
//   address     register index
//   chipselect  bus select
//   write_n     active-low write; a read is chipselect & write_n
//   writedata   write data
//   readdata    registered read data, valid the cycle after the read
//   irq         level interrupt
//
// Register map
//   0 STATUS   [0] sec_event, [1] alarm_event (write 1 to clear), [2] running
//   1 CONTROL  [0] run, [1] sec_irq_en, [2] alarm_irq_en, [3] alarm_en
//   2 TIME_HM  hh:mm BCD (reading it snapshots seconds and ms)
//   3 TIME_S   seconds BCD (reads return the snapshot)
//   4 MS       ms binary, read-only (reads return the snapshot)
//   5 ALARM_HM hh:mm BCD
//   6,7        read 0, writes ignored
module watch_rtc_core #(
  parameter int TICK_DIV = 1,
  parameter int MS_WRAP  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);
  localparam logic [9:0] MS_LAST  = 10'(MS_WRAP - 1);

  logic        tick_d;
  logic [7:0]  prescale;
  logic [9:0]  ms;
  logic [7:0]  sec;
  logic [7:0]  min;
  logic [7:0]  hour;
  logic [15:0] alarm_hm;
  logic [3:0]  ctrl;
  logic        sec_event;
  logic        alarm_event;
  logic [7:0]  shadow_sec;
  logic [9:0]  shadow_ms;

  logic        wr;
  logic        rd;
  logic        tick_edge;
  logic        ms_step;
  logic        step_ok;
  logic        sec_carry;
  logic        min_carry;
  logic        hour_carry;
  logic        wr_hm_ok;
  logic        wr_s_ok;
  logic        wr_alarm_ok;
  logic        alarm_hit;
  logic        sec_clr;
  logic        alarm_clr;
  logic [9:0]  ms_nxt;
  logic [7:0]  sec_nxt;
  logic [7:0]  min_nxt;
  logic [7:0]  hour_nxt;
  logic [7:0]  hour_after;

  // Both digits must be decimal and the whole value must not exceed max.
  // For valid BCD, comparing the raw byte orders the same as the number.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Two-digit BCD increment without range wrap; callers handle the wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    wr          = chipselect & ~write_n;
    rd          = chipselect & write_n;
    tick_edge   = tick_in & ~tick_d & ctrl[0];
    ms_step     = tick_edge && (prescale == PRE_LAST);

    sec_carry   = ms_step && (ms == MS_LAST);
    min_carry   = sec_carry && (sec == 8'h59);
    hour_carry  = min_carry && (min == 8'h59);

    ms_nxt      = (ms == MS_LAST) ? 10'd0 : ms + 10'd1;
    sec_nxt     = (sec == 8'h59)  ? 8'h00 : bcd_inc(sec);
    min_nxt     = (min == 8'h59)  ? 8'h00 : bcd_inc(min);
    hour_nxt    = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
    hour_after  = hour_carry ? hour_nxt : hour;

    wr_hm_ok    = wr && (address == 3'd2) &&
                  bcd_ok(writedata[15:8], 8'h23) && bcd_ok(writedata[7:0], 8'h59);
    wr_s_ok     = wr && (address == 3'd3) && bcd_ok(writedata[7:0], 8'h59);
    wr_alarm_ok = wr && (address == 3'd5) &&
                  bcd_ok(writedata[15:8], 8'h23) && bcd_ok(writedata[7:0], 8'h59);

    // A software time write in the same cycle wins; the ms step is dropped
    // together with any events it would have produced.
    step_ok     = ms_step && !wr_hm_ok && !wr_s_ok;

    // Alarm compares the hh:mm that results from a 59 -> 00 seconds rollover.
    alarm_hit   = step_ok && min_carry && ctrl[3] &&
                  ({hour_after, min_nxt} == alarm_hm);

    sec_clr     = wr && (address == 3'd0) && writedata[0];
    alarm_clr   = wr && (address == 3'd0) && writedata[1];
  end

  // Tick edge detection and the ms prescaler. A TIME_S write restarts the
  // current millisecond from scratch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d   <= 1'b0;
      prescale <= 8'd0;
    end else begin
      tick_d <= tick_in;
      if (wr_s_ok)
        prescale <= 8'd0;
      else if (tick_edge)
        prescale <= (prescale == PRE_LAST) ? 8'd0 : prescale + 8'd1;
    end
  end

  // Time-of-day counters with the full carry chain resolved in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms   <= 10'd0;
      sec  <= 8'h00;
      min  <= 8'h00;
      hour <= 8'h00;
    end else if (wr_hm_ok) begin
      hour <= writedata[15:8];
      min  <= writedata[7:0];
    end else if (wr_s_ok) begin
      sec <= writedata[7:0];
      ms  <= 10'd0;
    end else if (step_ok) begin
      ms <= ms_nxt;
      if (sec_carry)  sec  <= sec_nxt;
      if (min_carry)  min  <= min_nxt;
      if (hour_carry) hour <= hour_nxt;
    end
  end

  // Control, alarm and event flags. A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl        <= 4'd0;
      alarm_hm    <= 16'h0000;
      sec_event   <= 1'b0;
      alarm_event <= 1'b0;
    end else begin
      if (wr && (address == 3'd1))
        ctrl <= writedata[3:0];
      if (wr_alarm_ok)
        alarm_hm <= writedata;
      sec_event   <= (step_ok && sec_carry) || (sec_event && !sec_clr);
      alarm_event <= alarm_hit || (alarm_event && !alarm_clr);
    end
  end

  // Reading TIME_HM snapshots seconds and ms so the following TIME_S and
  // MS reads are coherent with it, even if ticks arrive in between.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_sec <= 8'h00;
      shadow_ms  <= 10'd0;
    end else if (rd && (address == 3'd2)) begin
      shadow_sec <= sec;
      shadow_ms  <= ms;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 16'h0000;
    end else begin
      case (address)
        3'd0:    readdata <= {13'd0, ctrl[0], alarm_event, sec_event};
        3'd1:    readdata <= {12'd0, ctrl};
        3'd2:    readdata <= {hour, min};
        3'd3:    readdata <= {8'd0, shadow_sec};
        3'd4:    readdata <= {6'd0, shadow_ms};
        3'd5:    readdata <= alarm_hm;
        default: readdata <= 16'h0000;
      endcase
    end
  end

  assign irq = (sec_event & ctrl[1]) | (alarm_event & ctrl[2]);

endmodule
